// File: rtl/regfile_mp_clr.sv
// Multi-port register file: registered reads with optional write bypass,
// highest-index write priority with collision flags, and a clear sequencer.
module regfile_mp_clr #(
  parameter  int DEPTH  = 80,
  parameter  int WIDTH  = 64,
  parameter  int NR     = 6,
  parameter  int NW     = 3,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NR-1:0]       r_en,
  input  logic [NR*AW-1:0]    r_addr,
  output logic [NR*WIDTH-1:0] r_data,
  input  logic [NW-1:0]       w_en,
  input  logic [NW*AW-1:0]    w_addr,
  input  logic [NW*WIDTH-1:0] w_data,
  input  logic                clr_req,
  output logic                busy,
  output logic [NW-1:0]       w_collide
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_ptr_q, clr_ptr_d;
  logic                busy_q;
  logic [NR*WIDTH-1:0] r_data_q, r_data_d;
  logic [NW-1:0]       w_collide_q, w_collide_d;
  logic [NW-1:0]       w_valid;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  // A write port is live only in IDLE and only for an in-range address.
  always_comb begin
    w_valid = '0;
    for (int k = 0; k < NW; k++) begin
      w_valid[k] = w_en[k] && !busy_q &&
                   ({1'b0, w_addr[k*AW +: AW]} < DEPTH_L);
    end
  end

  always_comb begin
    w_collide_d = '0;
    for (int k = 0; k < NW; k++) begin
      for (int j = k + 1; j < NW; j++) begin
        if (w_valid[k] && w_valid[j] &&
            (w_addr[k*AW +: AW] == w_addr[j*AW +: AW])) begin
          w_collide_d[k] = 1'b1;
        end
      end
    end
  end

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;
    r_data_d = r_data_q;
    ra       = '0;
    rv       = '0;
    for (int i = 0; i < NR; i++) begin
      ra = r_addr[i*AW +: AW];
      rv = '0;
      if (busy_q) begin
        r_data_d[i*WIDTH +: WIDTH] = '0;
      end else if (r_en[i]) begin
        if ({1'b0, ra} < DEPTH_L) begin
          rv = mem_q[ra];
          // Ascending scan leaves the highest-index matching write in rv.
          if (BYPASS) begin
            for (int k = 0; k < NW; k++) begin
              if (w_valid[k] && (w_addr[k*AW +: AW] == ra)) begin
                rv = w_data[k*WIDTH +: WIDTH];
              end
            end
          end
        end
        r_data_d[i*WIDTH +: WIDTH] = rv;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      busy_q      <= 1'b1;
      r_data_q    <= '0;
      w_collide_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      busy_q      <= (state_d == CLEAR);
      r_data_q    <= r_data_d;
      w_collide_q <= w_collide_d;
    end
  end

  // NOTE: the array has no reset branch; the CLEAR walk is what zeroes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        for (int k = 0; k < NW; k++) begin
          if (w_valid[k]) begin
            mem_q[w_addr[k*AW +: AW]] <= w_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign r_data    = r_data_q;
  assign busy      = busy_q;
  assign w_collide = w_collide_q;

endmodule
